// File: rtl/leitor_aprovados.sv
// Consumer of the active-node evaluator output: snapshots an approved batch, writes predecessors,
// and streams approved nodes (lowest slot first) to the valid-neighbour locator.
module leitor_aprovados #(
  parameter int NUM_NA          = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              aa_pronto_in,
  input  logic [NUM_NA-1:0]                 aa_aprovado_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_in,
  input  logic [ADDR_WIDTH-1:0]             destino_in,
  input  logic                              lvv_ready_in,
  output logic                              la_valid_out,
  output logic [ADDR_WIDTH-1:0]             la_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]        la_distancia_out,
  output logic                              la_destino_out,
  output logic                              la_anterior_wr_en_out,
  output logic [ADDR_WIDTH-1:0]             la_anterior_addr_out,
  output logic [ADDR_WIDTH-1:0]             la_anterior_data_out,
  output logic                              la_concluido_out,
  output logic                              la_ocupado_out
);

  localparam int IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    VARRER    = 2'd1,
    ENVIAR    = 2'd2,
    CONCLUIDO = 2'd3
  } estado_t;

  estado_t                             estado_q, estado_d;
  logic [NUM_NA-1:0]                   pend_q, pend_d;
  logic [ADDR_WIDTH*NUM_NA-1:0]        end_q, end_d;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0]   dist_q, dist_d;
  logic [ADDR_WIDTH*NUM_NA-1:0]        ant_q, ant_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic                                consumido_q, consumido_d;
  logic                                wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]               wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]               wr_data_q, wr_data_d;
  logic                                concluido_q, concluido_d;
  logic                                ocupado_q, ocupado_d;

  logic [IDX_W-1:0]                    sel_s;
  logic [ADDR_WIDTH-1:0]               end_cur_s;
  logic [DISTANCIA_WIDTH-1:0]          dist_cur_s;

  // Lowest set slot wins; scanning downward lets the final hit be the smallest index.
  function automatic logic [IDX_W-1:0] menor_idx(input logic [NUM_NA-1:0] mask);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_NA - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign sel_s      = menor_idx(pend_q);
  assign end_cur_s  = end_q[ADDR_WIDTH*idx_q +: ADDR_WIDTH];
  assign dist_cur_s = dist_q[DISTANCIA_WIDTH*idx_q +: DISTANCIA_WIDTH];

  // Next-state, snapshot capture and registered-output decode.
  always_comb begin
    estado_d    = estado_q;
    pend_d      = pend_q;
    end_d       = end_q;
    dist_d      = dist_q;
    ant_d       = ant_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    concluido_d = 1'b0;
    if (!aa_pronto_in) begin
      consumido_d = 1'b0;
    end else begin
      consumido_d = consumido_q;
    end

    case (estado_q)
      OCIOSO: begin
        if (aa_pronto_in && !consumido_q) begin
          estado_d = VARRER;
          pend_d   = aa_aprovado_in;
          end_d    = aa_endereco_in;
          dist_d   = aa_distancia_in;
          ant_d    = aa_anterior_data_in;
        end else begin
          estado_d = OCIOSO;
        end
      end
      VARRER: begin
        if (pend_q == '0) begin
          estado_d    = CONCLUIDO;
          concluido_d = 1'b1;
          consumido_d = 1'b1;
        end else begin
          // The write strobe fires only on entry to ENVIAR, so a stall never repeats it.
          estado_d  = ENVIAR;
          idx_d     = sel_s;
          wr_en_d   = 1'b1;
          wr_addr_d = end_q[ADDR_WIDTH*sel_s +: ADDR_WIDTH];
          wr_data_d = ant_q[ADDR_WIDTH*sel_s +: ADDR_WIDTH];
        end
      end
      ENVIAR: begin
        if (lvv_ready_in) begin
          pend_d[idx_q] = 1'b0;
          estado_d      = VARRER;
        end else begin
          estado_d = ENVIAR;
        end
      end
      CONCLUIDO: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    ocupado_d = (estado_d != OCIOSO);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      pend_q      <= '0;
      end_q       <= '0;
      dist_q      <= '0;
      ant_q       <= '0;
      idx_q       <= '0;
      consumido_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      concluido_q <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      pend_q      <= pend_d;
      end_q       <= end_d;
      dist_q      <= dist_d;
      ant_q       <= ant_d;
      idx_q       <= idx_d;
      consumido_q <= consumido_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      concluido_q <= concluido_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign la_valid_out          = (estado_q == ENVIAR);
  assign la_endereco_out       = la_valid_out ? end_cur_s : '0;
  assign la_distancia_out      = la_valid_out ? dist_cur_s : '0;
  assign la_destino_out        = la_valid_out && (end_cur_s == destino_in);
  assign la_anterior_wr_en_out = wr_en_q;
  assign la_anterior_addr_out  = wr_addr_q;
  assign la_anterior_data_out  = wr_data_q;
  assign la_concluido_out      = concluido_q;
  assign la_ocupado_out        = ocupado_q;

endmodule
